// File: rtl/tcm_arbiter.sv
// Two-port valid/ready arbiter in front of a single-port TCM.
// Fixed three-phase transaction per access with a contention counter.
module tcm_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [31:0]           wait_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [1:0]  win;
  logic [1:0]  own;
  logic        pend;
  logic [31:0] sel_addr;
  logic [3:0]  sel_wstrb;
  logic        is_read;
  logic        addr_unused;

  // last holds the index of the port served most recently
  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (m0_valid && m1_valid):
        win = (FIXED_PRIO || last) ? 2'b01 : 2'b10;
      (m0_valid ^ m1_valid):
        win = {m1_valid, m0_valid};
      default: win = 2'b00;
    endcase
  end

  assign own  = (state == IDLE) ? win : grant;
  assign pend = (m0_valid & ~own[0]) | (m1_valid & ~own[1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= 2'b00;
      last        <= 1'b1;
      wait_cycles <= 32'd0;
    end else begin
      if (state == IDLE) begin
        grant <= win;
      end else if (state == RESP) begin
        grant <= 2'b00;
        last  <= grant[1];
      end
      if (pend && (wait_cycles != 32'hFFFF_FFFF)) begin
        wait_cycles <= wait_cycles + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = (|win) ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_addr    = grant[1] ? m1_addr : m0_addr;
  assign sel_wstrb   = grant[1] ? m1_wstrb : m0_wstrb;
  assign is_read     = (sel_wstrb == 4'b0000);
  assign addr_unused = ^sel_addr[31:ADDR_WIDTH];

  always_comb begin
    mem_en    = (state == ACCESS);
    mem_addr  = sel_addr[ADDR_WIDTH-1:0];
    mem_wdata = grant[1] ? m1_wdata : m0_wdata;
    mem_wstrb = mem_en ? sel_wstrb : 4'b0000;
    m0_ready  = (state == RESP) && grant[0];
    m1_ready  = (state == RESP) && grant[1];
    m0_rdata  = (m0_ready && is_read) ? mem_rdata : 32'd0;
    m1_rdata  = (m1_ready && is_read) ? mem_rdata : 32'd0;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: per-cycle vector table plus reset,
// fixed-priority and counter-saturation sequences.
module tb_tcm_arbiter;

  localparam logic [31:0] A0  = 32'h0001_0010;
  localparam logic [31:0] A10 = 32'h0000_0010;
  localparam logic [31:0] A20 = 32'h0000_0020;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] RB  = 32'hAA22_CCDD;
  localparam logic [31:0] WD  = 32'h1122_3344;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        m0_valid = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m1_valid = 1'b0;
  logic [31:0] m1_addr = '0;
  logic [31:0] m1_wdata = WD;
  logic [3:0]  m1_wstrb = '0;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  grant;
  logic        busy;
  logic [31:0] wait_cycles;

  logic        f_m0_valid = 1'b0;
  logic        f_m1_valid = 1'b0;
  logic [31:0] f_m0_rdata;
  logic        f_m0_ready;
  logic [31:0] f_m1_rdata;
  logic        f_m1_ready;
  logic        f_mem_en;
  logic [15:0] f_mem_addr;
  logic [31:0] f_mem_wdata;
  logic [3:0]  f_mem_wstrb;
  logic [31:0] f_mem_rdata = '0;
  logic [1:0]  f_grant;
  logic        f_busy;
  logic [31:0] f_wait_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tcm_arbiter #(.ADDR_WIDTH(16), .FIXED_PRIO(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy), .wait_cycles(wait_cycles)
  );

  tcm_arbiter #(.ADDR_WIDTH(16), .FIXED_PRIO(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .m0_valid(f_m0_valid), .m0_addr(A10), .m0_wdata(32'd0),
    .m0_wstrb(4'd0), .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready),
    .m1_valid(f_m1_valid), .m1_addr(A20), .m1_wdata(32'd0),
    .m1_wstrb(4'd0), .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready),
    .mem_en(f_mem_en), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_wstrb(f_mem_wstrb), .mem_rdata(f_mem_rdata),
    .grant(f_grant), .busy(f_busy), .wait_cycles(f_wait_cycles)
  );

  logic [31:0] mem [0:255];

  always @(posedge clock) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b])
          mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  always @(posedge clock) begin
    if (f_mem_en) f_mem_rdata <= {16'hCAFE, f_mem_addr};
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic        v1;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic        r0;
    logic [31:0] d0;
    logic        r1;
    logic [31:0] d1;
    logic [1:0]  g;
    logic        en;
    logic [15:0] ma;
    logic [3:0]  ws;
    logic        b;
    logic [31:0] w;
  } vec_t;

  vec_t tv[$];

  task automatic add(input vec_t t);
    tv.push_back(t);
  endtask

  task automatic check(input string name, input logic ok,
                       input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic run_table();
    foreach (tv[i]) begin
      vec_t t;
      logic ok;
      t = tv[i];
      @(negedge clock);
      m0_valid = t.v0; m0_addr = t.a0; m0_wstrb = t.s0;
      m1_valid = t.v1; m1_addr = t.a1; m1_wstrb = t.s1;
      #1;
      ok = (m0_ready === t.r0) && (m0_rdata === t.d0) &&
           (m1_ready === t.r1) && (m1_rdata === t.d1) &&
           (grant === t.g) && (mem_en === t.en) &&
           (mem_wstrb === t.ws) && (busy === t.b) &&
           (wait_cycles === t.w);
      if (t.en && mem_addr !== t.ma) ok = 1'b0;
      if (t.ws != 4'd0 && mem_wdata !== WD) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d got r0=%b d0=%h r1=%b d1=%h g=%b en=%b a=%h ws=%b b=%b w=%0d want r0=%b d0=%h r1=%b d1=%h g=%b en=%b a=%h ws=%b b=%b w=%0d",
                 i, m0_ready, m0_rdata, m1_ready, m1_rdata, grant, mem_en,
                 mem_addr, mem_wstrb, busy, wait_cycles,
                 t.r0, t.d0, t.r1, t.d1, t.g, t.en, t.ma, t.ws, t.b, t.w);
      end
    end
  endtask

  initial begin
    int bad;
    int rdy;
    bit found;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[4] = DB;
    mem[8] = RB;

    // single read on port 0
    add('{1, A0, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    add('{1, A0, 0, 0, 0, 0,  0, 0, 0, 0,  2'b01, 1, 16'h0010, 0, 1, 0});
    add('{1, A0, 0, 0, 0, 0,  1, DB, 0, 0, 2'b01, 0, 16'h0, 0, 1, 0});
    add('{0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    // byte write on port 1
    add('{0, 0, 0, 1, A20, 4, 0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    add('{0, 0, 0, 1, A20, 4, 0, 0, 0, 0,  2'b10, 1, 16'h0020, 4, 1, 0});
    add('{0, 0, 0, 1, A20, 4, 0, 0, 1, 0,  2'b10, 0, 16'h0, 0, 1, 0});
    add('{0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    // readback of the partially written word
    add('{1, A20, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    add('{1, A20, 0, 0, 0, 0, 0, 0, 0, 0,  2'b01, 1, 16'h0020, 0, 1, 0});
    add('{1, A20, 0, 0, 0, 0, 1, RB, 0, 0, 2'b01, 0, 16'h0, 0, 1, 0});
    add('{0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    // read on port 1
    add('{0, 0, 0, 1, A10, 0, 0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    add('{0, 0, 0, 1, A10, 0, 0, 0, 0, 0,  2'b10, 1, 16'h0010, 0, 1, 0});
    add('{0, 0, 0, 1, A10, 0, 0, 0, 1, DB, 2'b10, 0, 16'h0, 0, 1, 0});
    add('{0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    // round-robin contention, four transactions
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 0});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b01, 1, 16'h0010, 0, 1, 1});
    add('{1, A0, 0, 1, A20, 0, 1, DB, 0, 0, 2'b01, 0, 16'h0, 0, 1, 2});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 3});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b10, 1, 16'h0020, 0, 1, 4});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 1, RB, 2'b10, 0, 16'h0, 0, 1, 5});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 6});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b01, 1, 16'h0010, 0, 1, 7});
    add('{1, A0, 0, 1, A20, 0, 1, DB, 0, 0, 2'b01, 0, 16'h0, 0, 1, 8});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 9});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 0, 0,  2'b10, 1, 16'h0020, 0, 1, 10});
    add('{1, A0, 0, 1, A20, 0, 0, 0, 1, RB, 2'b10, 0, 16'h0, 0, 1, 11});
    add('{0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 16'h0, 0, 0, 12});

    repeat (2) @(negedge clock);
    #1;
    check("reset_state",
          (grant === 2'b00) && (busy === 1'b0) && (mem_en === 1'b0) &&
          (m0_ready === 1'b0) && (m1_ready === 1'b0) &&
          (mem_wstrb === 4'd0) && (wait_cycles === 32'd0) &&
          (m0_rdata === 32'd0) && (m1_rdata === 32'd0),
          {grant, busy, mem_en, m0_ready, m1_ready, wait_cycles}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_table();

    // fixed priority: port 1 starves while port 0 keeps requesting
    @(negedge clock);
    f_m0_valid = 1'b1;
    f_m1_valid = 1'b1;
    bad = 0;
    rdy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      #1;
      if (f_grant == 2'b10 || f_m1_ready) bad++;
      if (f_m0_ready) rdy++;
    end
    check("fixed_no_m1", bad == 0, 64'(bad), 64'd0);
    check("fixed_m0_count", rdy == 4, 64'(rdy), 64'd4);
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge clock);
      #1;
      if (f_m0_ready) found = 1'b1;
    end
    check("fixed_m0_resp_seen", found, 64'(found), 64'd1);
    @(negedge clock);
    f_m0_valid = 1'b0;
    @(negedge clock);
    #1;
    check("fixed_m1_granted", (f_grant === 2'b10) && (f_mem_en === 1'b1),
          {f_grant, f_mem_en}, {2'b10, 1'b1});
    @(negedge clock);
    #1;
    check("fixed_m1_ready", (f_m1_ready === 1'b1) && (f_m0_ready === 1'b0),
          {f_m1_ready, f_m0_ready}, 64'b10);
    f_m1_valid = 1'b0;

    // asynchronous reset while in ACCESS
    @(negedge clock);
    m0_valid = 1'b1; m0_addr = A0; m0_wstrb = 4'd0;
    @(posedge clock);
    #2;
    check("pre_reset_access", (mem_en === 1'b1) && (busy === 1'b1),
          {mem_en, busy}, 64'b11);
    reset_n = 1'b0;
    #1;
    check("async_reset",
          (mem_en === 1'b0) && (grant === 2'b00) && (busy === 1'b0) &&
          (wait_cycles === 32'd0),
          {mem_en, grant, busy, wait_cycles}, 64'd0);
    m0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      if (m0_ready || m1_ready || busy) bad++;
    end
    check("no_ready_after_reset", bad == 0, 64'(bad), 64'd0);
    check("wait_after_reset", wait_cycles === 32'd0,
          64'(wait_cycles), 64'd0);

    // counter saturation under continuous contention
    @(negedge clock);
    m0_valid = 1'b1; m0_addr = A0; m0_wstrb = 4'd0;
    m1_valid = 1'b1; m1_addr = A20; m1_wstrb = 4'd0;
    @(negedge clock);
    force dut0.wait_cycles = 32'hFFFF_FFFE;
    #1;
    release dut0.wait_cycles;
    @(negedge clock);
    #1;
    check("wait_reach_max", wait_cycles === 32'hFFFF_FFFF,
          64'(wait_cycles), 64'hFFFF_FFFF);
    repeat (3) @(negedge clock);
    #1;
    check("wait_hold_max", wait_cycles === 32'hFFFF_FFFF,
          64'(wait_cycles), 64'hFFFF_FFFF);
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
